// File: rtl/linebuff_pool_win.sv
// linebuff_pool_win: multi-channel 2x2 stride-2 pooling engine.
// Takes a raster-order stream of NUM_CH pixels and produces one pooled pixel
// per channel for each 2x2 window. Max or average is chosen by POOL_MODE.
// Optional macro LINEBUFF_POOL_RELU_EN clamps negative pooled results to 0.

// Per-channel datapath: a hold register for the even column, a half-width
// row buffer for the even row, and the output register.
module linebuff_pool_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_COLS   = 28,
  parameter int POOL_MODE  = 0,
  parameter int HW         = 4
) (
  input  logic                  gclk,
  input  logic                  grst_n,
  input  logic                  acc,
  input  logic                  col_odd,
  input  logic                  row_odd,
  input  logic [HW-1:0]         half_col,
  input  logic [DATA_WIDTH-1:0] pix,
  output logic [DATA_WIDTH-1:0] res
);
  // Row buffer entries are one bit wider so the average-mode pair sum fits.
  localparam int BW = DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] hold_reg;
  logic [BW-1:0]         row_buf [IMG_COLS/2];
  logic [BW-1:0]         pair;
  logic [BW-1:0]         prev;
  logic [DATA_WIDTH-1:0] pool;
  logic [DATA_WIDTH-1:0] pool_f;

  assign prev = row_buf[half_col];

  if (POOL_MODE == 1) begin : g_avg
    logic signed [DATA_WIDTH+1:0] quad;
    // Pair sum is exact in DATA_WIDTH+1 bits, the 4-pixel sum in +2 bits.
    assign pair = {hold_reg[DATA_WIDTH-1], hold_reg} + {pix[DATA_WIDTH-1], pix};
    assign quad = {prev[BW-1], prev} + {pair[BW-1], pair};
    // Arithmetic shift rounds toward -inf; the result always fits DATA_WIDTH.
    assign pool = DATA_WIDTH'(quad >>> 2);
  end else begin : g_max
    logic [DATA_WIDTH-1:0] pm;
    assign pm   = ($signed(hold_reg) > $signed(pix)) ? hold_reg : pix;
    assign pair = {pm[DATA_WIDTH-1], pm};
    assign pool = ($signed(prev) > $signed(pair)) ? prev[DATA_WIDTH-1:0]
                                                  : pair[DATA_WIDTH-1:0];
  end

`ifdef LINEBUFF_POOL_RELU_EN
  assign pool_f = pool[DATA_WIDTH-1] ? '0 : pool;
`else
  assign pool_f = pool;
`endif

  // Capture the even-column pixel of each horizontal pair.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                hold_reg <= '0;
    else if (acc && !col_odd)   hold_reg <= pix;
  end

  // Even rows deposit the horizontal pair result; odd rows only read it.
  always_ff @(posedge gclk) begin
    if (acc && col_odd && !row_odd) row_buf[half_col] <= pair;
  end

  // Register the pooled result on the odd-row, odd-column pixel.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                         res <= '0;
    else if (acc && col_odd && row_odd)  res <= pool_f;
  end
endmodule

module linebuff_pool_win #(
  parameter int NUM_CH     = 6,
  parameter int DATA_WIDTH = 16,
  parameter int IMG_COLS   = 28,
  parameter int IMG_ROWS   = 28,
  parameter int POOL_MODE  = 0
) (
  input  logic                               pw_clk,
  input  logic                               pw_rst_b,
  input  logic                               pw_clr_i,
  input  logic                               pw_in_valid_i,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  pw_in_data_i,
  output logic                               pw_out_valid_o,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]  pw_out_data_o,
  output logic                               pw_out_last_o
);
  localparam int CW = $clog2(IMG_COLS);
  localparam int RW = $clog2(IMG_ROWS);
  localparam int HW = (IMG_COLS / 2 > 1) ? $clog2(IMG_COLS / 2) : 1;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [HW-1:0] half_col;
  logic          acc;
  logic          fin;
  logic          col_end;
  logic          row_end;

  // A clear in the same cycle drops the incoming pixel.
  assign acc      = pw_in_valid_i && !pw_clr_i;
  assign col_end  = (col_cnt == CW'(IMG_COLS - 1));
  assign row_end  = (row_cnt == RW'(IMG_ROWS - 1));
  assign fin      = acc && col_cnt[0] && row_cnt[0];
  assign half_col = HW'(col_cnt >> 1);

  // Raster position tracking plus the registered valid/last pulse.
  always_ff @(posedge pw_clk or negedge pw_rst_b) begin
    if (!pw_rst_b) begin
      col_cnt        <= '0;
      row_cnt        <= '0;
      pw_out_valid_o <= 1'b0;
      pw_out_last_o  <= 1'b0;
    end else if (pw_clr_i) begin
      col_cnt        <= '0;
      row_cnt        <= '0;
      pw_out_valid_o <= 1'b0;
      pw_out_last_o  <= 1'b0;
    end else begin
      pw_out_valid_o <= fin;
      pw_out_last_o  <= fin && col_end && row_end;
      if (acc) begin
        if (col_end) begin
          col_cnt <= '0;
          row_cnt <= row_end ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    linebuff_pool_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .IMG_COLS   (IMG_COLS),
      .POOL_MODE  (POOL_MODE),
      .HW         (HW)
    ) u_lane (
      .gclk     (pw_clk),
      .grst_n   (pw_rst_b),
      .acc      (acc),
      .col_odd  (col_cnt[0]),
      .row_odd  (row_cnt[0]),
      .half_col (half_col),
      .pix      (pw_in_data_i[g]),
      .res      (pw_out_data_o[g])
    );
  end
endmodule

// File: tb/tb_linebuff_pool_win.sv
// Bench for linebuff_pool_win: a max-mode and an average-mode instance share
// one input stream; a frame-array reference model predicts every cycle.
module tb_linebuff_pool_win;
  localparam int NCH  = 6;
  localparam int DW   = 16;
  localparam int COLS = 28;
  localparam int ROWS = 28;
  localparam int NPIX = COLS * ROWS;

  logic                   clk = 1'b0;
  logic                   rst_b;
  logic                   clr;
  logic                   in_valid;
  logic [NCH-1:0][DW-1:0] din;
  logic                   mx_v, mx_l, av_v, av_l;
  logic [NCH-1:0][DW-1:0] mx_d, av_d;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: pixel index within frame and the frame image.
  int idx;
  int img [ROWS][COLS][NCH];
  logic                   exp_v, exp_l;
  logic [NCH-1:0][DW-1:0] exp_max, exp_avg;
  int mx_res, mx_last, av_res, av_last;

  always #5 clk = ~clk;

  linebuff_pool_win #(.NUM_CH(NCH), .DATA_WIDTH(DW), .IMG_COLS(COLS),
                      .IMG_ROWS(ROWS), .POOL_MODE(0)) dut_max (
    .pw_clk(clk), .pw_rst_b(rst_b), .pw_clr_i(clr), .pw_in_valid_i(in_valid),
    .pw_in_data_i(din), .pw_out_valid_o(mx_v), .pw_out_data_o(mx_d),
    .pw_out_last_o(mx_l));

  linebuff_pool_win #(.NUM_CH(NCH), .DATA_WIDTH(DW), .IMG_COLS(COLS),
                      .IMG_ROWS(ROWS), .POOL_MODE(1)) dut_avg (
    .pw_clk(clk), .pw_rst_b(rst_b), .pw_clr_i(clr), .pw_in_valid_i(in_valid),
    .pw_in_data_i(din), .pw_out_valid_o(av_v), .pw_out_data_o(av_d),
    .pw_out_last_o(av_l));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pool the 2x2 window whose bottom-right pixel is (r,c) straight from the image.
  function automatic logic [DW-1:0] pool_ref(int r, int c, int ch, bit avg);
    int a [4];
    int m, s;
    logic [DW-1:0] t;
    a[0] = img[r-1][c-1][ch]; a[1] = img[r-1][c][ch];
    a[2] = img[r][c-1][ch];   a[3] = img[r][c][ch];
    if (avg) begin
      s = a[0] + a[1] + a[2] + a[3];
      t = DW'(s >>> 2);
    end else begin
      m = a[0];
      for (int k = 1; k < 4; k++) if (a[k] > m) m = a[k];
      t = DW'(m);
    end
`ifdef LINEBUFF_POOL_RELU_EN
    if (t[DW-1]) t = '0;
`endif
    return t;
  endfunction

  function automatic logic [DW-1:0] relu_c(logic [DW-1:0] v);
`ifdef LINEBUFF_POOL_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // One clock: drive inputs, advance the model, compare all outputs.
  task automatic cycle(input logic v, input logic c);
    int r, col;
    in_valid = v;
    clr      = c;
    @(posedge clk); #1;
    exp_v = 1'b0;
    exp_l = 1'b0;
    if (c) begin
      idx = 0;
    end else if (v) begin
      r   = idx / COLS;
      col = idx % COLS;
      for (int ch = 0; ch < NCH; ch++) img[r][col][ch] = int'($signed(din[ch]));
      if ((r % 2 == 1) && (col % 2 == 1)) begin
        exp_v = 1'b1;
        exp_l = (idx == NPIX - 1);
        for (int ch = 0; ch < NCH; ch++) begin
          exp_max[ch] = pool_ref(r, col, ch, 1'b0);
          exp_avg[ch] = pool_ref(r, col, ch, 1'b1);
        end
      end
      idx = (idx + 1) % NPIX;
    end
    if (mx_v === 1'b1) mx_res++;
    if (mx_l === 1'b1) mx_last++;
    if (av_v === 1'b1) av_res++;
    if (av_l === 1'b1) av_last++;
    chk("max_valid", 128'(mx_v), 128'(exp_v));
    chk("max_last",  128'(mx_l), 128'(exp_l));
    chk("max_data",  128'(mx_d), 128'(exp_max));
    chk("avg_valid", 128'(av_v), 128'(exp_v));
    chk("avg_last",  128'(av_l), 128'(exp_l));
    chk("avg_data",  128'(av_d), 128'(exp_avg));
  endtask

  task automatic rand_din();
    for (int ch = 0; ch < NCH; ch++) din[ch] = DW'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mv"}, 128'(mx_v), 128'(0));
    chk({tag, "_ml"}, 128'(mx_l), 128'(0));
    chk({tag, "_md"}, 128'(mx_d), 128'(0));
    chk({tag, "_av"}, 128'(av_v), 128'(0));
    chk({tag, "_al"}, 128'(av_l), 128'(0));
    chk({tag, "_ad"}, 128'(av_d), 128'(0));
  endtask

  initial begin
    int fed;
    // Step 1: power-on reset state.
    rst_b = 1'b0; clr = 1'b0; in_valid = 1'b0; din = '0;
    idx = 0; exp_v = 0; exp_l = 0; exp_max = '0; exp_avg = '0;
    mx_res = 0; mx_last = 0; av_res = 0; av_last = 0;
    #3;
    chk_zero("reset");
    @(posedge clk); #1;
    rst_b = 1'b1;

    // Step 2: first window {-1,-2,-3,-4}; max -> -1, avg -> -3.
    for (int i = 0; i < 30; i++) begin
      rand_din();
      if (i == 0)  din = {NCH{16'hFFFF}};
      if (i == 1)  din = {NCH{16'hFFFE}};
      if (i == 28) din = {NCH{16'hFFFD}};
      if (i == 29) din = {NCH{16'hFFFC}};
      cycle(1'b1, 1'b0);
    end
    chk("win_max_ch0", 128'(mx_d[0]), 128'(relu_c(16'hFFFF)));
    chk("win_avg_ch0", 128'(av_d[0]), 128'(relu_c(16'hFFFD)));
    chk("win_valid",   128'(av_v),    128'(1));

    // Step 3: asynchronous reset mid-frame while a result is showing.
    rst_b = 1'b0; in_valid = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk); #1;
    rst_b = 1'b1;
    idx = 0; exp_v = 0; exp_l = 0; exp_max = '0; exp_avg = '0;
    for (int i = 0; i < 60; i++) begin
      rand_din();
      cycle(1'b1, 1'b0);
    end

    // Step 4: clear at row 3, col 5 with valid; that pixel is dropped.
    while (idx != 3 * COLS + 5) begin
      rand_din();
      cycle(($urandom_range(0, 3) != 0), 1'b0);
    end
    rand_din();
    cycle(1'b1, 1'b1);
    chk("clr_no_out", 128'(mx_v), 128'(0));

    // Step 5: extremes; rows 0-1 all 0x7FFF, rows 2-3 all 0x8000.
    for (int i = 0; i < 4 * COLS; i++) begin
      din = (i < 2 * COLS) ? {NCH{16'h7FFF}} : {NCH{16'h8000}};
      cycle(1'b1, 1'b0);
      if (i == 29)            chk("ext_avg_7fff", 128'(av_d[0]), 128'(16'h7FFF));
      if (i == 2 * COLS + 29) chk("ext_max_8000", 128'(mx_d[0]), 128'(relu_c(16'h8000)));
    end

    // Step 6: three back-to-back frames with ~50% valid duty.
    rand_din();
    cycle(1'b0, 1'b1);
    mx_res = 0; mx_last = 0; av_res = 0; av_last = 0;
    fed = 0;
    while (fed < 3 * NPIX) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      rand_din();
      cycle(v, 1'b0);
      if (v) fed++;
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    chk("max_results", 128'(mx_res),  128'(3 * (ROWS / 2) * (COLS / 2)));
    chk("max_lasts",   128'(mx_last), 128'(3));
    chk("avg_results", 128'(av_res),  128'(3 * (ROWS / 2) * (COLS / 2)));
    chk("avg_lasts",   128'(av_last), 128'(3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
